mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single Sysbus memory port between the instruction-cache line fill, the data-cache line fill and the data-cache dirty-line writeback. Each transfer is one 64-byte line carried as eight 64-bit beats. The block sequences the Sysbus request, ack and response handshake for the granted requester. It reports progress to that cache as a bit offset counting up to 512, which is the completion condition both caches test.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, Sysbus data/address beat width
- BUS_TAG_WIDTH, 13, Sysbus tag width

Ports (all widths in bits):
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- ic_req  in  1  icache fill request, level, held until ic_offset==512
- ic_addr  in  64  icache fill address, [5:0] ignored
- ic_line  out  512  assembled icache line
- ic_offset  out  10  bits delivered to icache, 0..512
- dc_fill_req  in  1  dcache fill request, level
- dc_fill_addr  in  64  dcache fill address, [5:0] ignored
- dc_wb_req  in  1  dcache writeback request, level
- dc_wb_addr  in  64  writeback line address, [5:0] ignored
- dc_wb_data  in  512  line to write back
- dc_line  out  512  assembled dcache fill line
- dc_offset  out  10  fill bits delivered to dcache, 0..512
- dc_wb_offset  out  10  writeback bits sent, 0..512
- bus_reqcyc  out  1  Sysbus request valid
- bus_req  out  64  address beat, then write data beats
- bus_reqtag  out  13  {op (1 = read, 0 = write), `SYSBUS_MEMORY, zeros}, from Sysbus.defs
- bus_reqack  in  1  Sysbus accepted request
- bus_respcyc  in  1  response beat valid
- bus_resp  in  64  response data beat
- bus_resptag  in  13  response tag, ignored
- bus_respack  out  1  response beat accepted

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE. A registered grant holds one of IC, DCF or DCW.
- Arbitration in IDLE:
  - dc_wb_req wins outright.
  - Otherwise ic_req and dc_fill_req alternate round-robin through a last_fill bit. Reset value of last_fill is IC, so DCF wins the first tie.
  - The winning address is latched with [5:0] forced to 0.
  - Next state is WR_ADDR for DCW and RD_ADDR for the fills.
- RD_ADDR:
  - Drive bus_reqcyc=1, bus_req=latched address, bus_reqtag=read.
  - Hold until bus_reqack, then go to RD_DATA and clear the beat count.
- RD_DATA:
  - bus_respack = bus_respcyc, combinationally.
  - On each bus_respcyc, write bus_resp to line[64*cnt +: 64] of the granted line, increment cnt and add 64 to the granted offset.
  - On the 8th beat go to DONE. Cycles without respcyc are stalls with no change.
- WR_ADDR:
  - Drive bus_reqcyc=1, bus_req=address, bus_reqtag=write.
  - On bus_reqack, latch dc_wb_data into the write buffer and go to WR_DATA.
- WR_DATA:
  - For cnt = 0..7, drive bus_reqcyc=1 and bus_req=buffer[64*cnt +: 64], one beat per cycle unconditionally.
  - dc_wb_offset increments by 64 per beat. After beat 7 go to DONE.
- DONE:
  - The granted offset reads 512 for exactly this cycle.
  - Next cycle: offset returns to 0, state returns to IDLE, and requests are re-arbitrated.
  - last_fill updates to the just-finished fill requester. A DCW grant leaves it unchanged.
- Request deassertion:
  - Requesters drop their req in the cycle after seeing 512.
  - A req still high on the IDLE cycle after DONE is treated as a new request.
  - A req that drops mid-transfer does not abort it. The transfer completes and its data is discarded.
- ic_line and dc_line hold their last assembled value until overwritten by the next fill for that cache.

## Timing
- Reset values:
  - All outputs are 0: reqcyc, req, reqtag, respack, all offsets, ic_line, dc_line.
  - State is IDLE, cnt is 0, last_fill is IC.
- Reset asserted mid-transfer returns to IDLE on the next edge. No beats are issued after that, and the partial line is not signalled (offset returns to 0).
- Minimum latency from req to 512:
  - Fill: 1 (IDLE) + 1 (addr, ack same cycle) + 8 (beats, respcyc every cycle) = 10 cycles.
  - Writeback: 1 + 1 + 8 = 10 cycles.
- Outputs are registered except bus_respack.
- Requests arriving outside IDLE wait. Arbitration samples only in IDLE.
- dc_wb_req and dc_fill_req are high together when the dcache must evict: the writeback always completes first.

## Test plan
- Single icache fill: ic_req with ic_addr=0x1047; expect bus_req=0x1040 with read tag. Respond with beats 0x11..0x88, one per cycle. Expect ic_line[63:0]=0x11 and [511:448]=0x88, and ic_offset=512 for one cycle, 10 cycles after req.
- Dirty eviction: dc_wb_req and dc_fill_req asserted together. Expect the write (8 beats equal to dc_wb_data slices, dc_wb_offset reaching 512) before the fill read is issued.
- Round-robin: ic_req and dc_fill_req held continuously. Grants go DCF, IC, DCF, IC across four transfers.
- Stalled response: respcyc pattern 1,0,0,1,1,0,1,1,1,1,1. Offset steps only on valid beats, and respack mirrors respcyc.
- Delayed ack: hold bus_reqack low for 5 cycles. bus_reqcyc, address and tag stay stable, and no beats are issued early.
- Reset after the 4th read beat: all outputs are 0 the next cycle, no 512 pulse, and a fresh request then completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single Sysbus memory port between the icache line
// fill, the dcache line fill and the dcache dirty-line writeback. Each grant
// moves one 64-byte line as eight beats and reports progress as a bit offset
// that reaches 512 for exactly one cycle when the line is complete.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ic_req,
    input  logic [BUS_DATA_WIDTH-1:0] ic_addr,
    output logic [511:0]              ic_line,
    output logic [9:0]                ic_offset,
    input  logic                      dc_fill_req,
    input  logic [BUS_DATA_WIDTH-1:0] dc_fill_addr,
    input  logic                      dc_wb_req,
    input  logic [BUS_DATA_WIDTH-1:0] dc_wb_addr,
    input  logic [511:0]              dc_wb_data,
    output logic [511:0]              dc_line,
    output logic [9:0]                dc_offset,
    output logic [9:0]                dc_wb_offset,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    // Sysbus request tag: {op, device type, zeros}; memory device type is 4'b0001
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_READ  = {1'b1, SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = {1'b0, SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};
    localparam logic [9:0] BEAT_BITS = 10'd64;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE} state_t;
    typedef enum logic [1:0] {G_IC, G_DCF, G_DCW} grant_t;

    state_t                    state_reg;
    grant_t                    grant_reg;
    logic                      last_fill_reg;   // 0: icache filled last, 1: dcache filled last
    logic [2:0]                cnt_reg;
    logic [511:0]              wbuf_reg;
    logic                      bus_reqcyc_reg;
    logic [BUS_DATA_WIDTH-1:0] bus_req_reg;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_reg;
    logic [9:0]                ic_offset_reg;
    logic [9:0]                dc_offset_reg;
    logic [9:0]                dc_wb_offset_reg;

    logic                      fill_pick_dcf;
    logic [BUS_DATA_WIDTH-1:0] fill_addr;
    logic                      beat_fire;
    logic                      unused_bits;

    // Round-robin between the two fills: dcache wins unless icache also wants
    // the bus and dcache was the last one served.
    assign fill_pick_dcf = dc_fill_req && (!ic_req || !last_fill_reg);
    assign fill_addr     = fill_pick_dcf ? dc_fill_addr : ic_addr;
    assign beat_fire     = (state_reg == RD_DATA) && bus_respcyc;

    assign bus_respack  = beat_fire;
    assign bus_reqcyc   = bus_reqcyc_reg;
    assign bus_req      = bus_req_reg;
    assign bus_reqtag   = bus_reqtag_reg;
    assign ic_offset    = ic_offset_reg;
    assign dc_offset    = dc_offset_reg;
    assign dc_wb_offset = dc_wb_offset_reg;

    // Response tag and the in-line byte offset of request addresses carry no information here
    assign unused_bits = ^{bus_resptag, ic_addr[5:0], dc_fill_addr[5:0], dc_wb_addr[5:0]};

    // Transfer sequencer: arbitrates in IDLE and drives the registered bus request and offsets
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            grant_reg        <= G_IC;
            last_fill_reg    <= 1'b0;
            cnt_reg          <= '0;
            bus_reqcyc_reg   <= 1'b0;
            bus_req_reg      <= '0;
            bus_reqtag_reg   <= '0;
            ic_offset_reg    <= '0;
            dc_offset_reg    <= '0;
            dc_wb_offset_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dc_wb_req) begin
                        grant_reg      <= G_DCW;
                        state_reg      <= WR_ADDR;
                        bus_reqcyc_reg <= 1'b1;
                        bus_req_reg    <= {dc_wb_addr[BUS_DATA_WIDTH-1:6], 6'b0};
                        bus_reqtag_reg <= TAG_WRITE;
                    end else if (ic_req || dc_fill_req) begin
                        grant_reg      <= fill_pick_dcf ? G_DCF : G_IC;
                        state_reg      <= RD_ADDR;
                        bus_reqcyc_reg <= 1'b1;
                        bus_req_reg    <= {fill_addr[BUS_DATA_WIDTH-1:6], 6'b0};
                        bus_reqtag_reg <= TAG_READ;
                    end
                end
                RD_ADDR: begin
                    if (bus_reqack) begin
                        state_reg      <= RD_DATA;
                        cnt_reg        <= '0;
                        bus_reqcyc_reg <= 1'b0;
                        bus_req_reg    <= '0;
                        bus_reqtag_reg <= '0;
                    end
                end
                RD_DATA: begin
                    if (bus_respcyc) begin
                        cnt_reg <= cnt_reg + 3'd1;
                        if (grant_reg == G_IC) ic_offset_reg <= ic_offset_reg + BEAT_BITS;
                        else                   dc_offset_reg <= dc_offset_reg + BEAT_BITS;
                        if (cnt_reg == 3'd7) state_reg <= DONE;
                    end
                end
                WR_ADDR: begin
                    if (bus_reqack) begin
                        state_reg   <= WR_DATA;
                        cnt_reg     <= '0;
                        bus_req_reg <= dc_wb_data[BUS_DATA_WIDTH-1:0];
                    end
                end
                WR_DATA: begin
                    dc_wb_offset_reg <= dc_wb_offset_reg + BEAT_BITS;
                    if (cnt_reg == 3'd7) begin
                        state_reg      <= DONE;
                        bus_reqcyc_reg <= 1'b0;
                        bus_req_reg    <= '0;
                        bus_reqtag_reg <= '0;
                    end else begin
                        cnt_reg     <= cnt_reg + 3'd1;
                        bus_req_reg <= wbuf_reg[(int'(cnt_reg) + 1) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    end
                end
                DONE: begin
                    state_reg        <= IDLE;
                    ic_offset_reg    <= '0;
                    dc_offset_reg    <= '0;
                    dc_wb_offset_reg <= '0;
                    case (grant_reg)
                        G_IC:    last_fill_reg <= 1'b0;
                        G_DCF:   last_fill_reg <= 1'b1;
                        default: ;
                    endcase
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Writeback line is snapshotted when the bus accepts the write request
    always_ff @(posedge clk) begin
        if (state_reg == WR_ADDR && bus_reqack) wbuf_reg <= dc_wb_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_beat
            logic [BUS_DATA_WIDTH-1:0] ic_beat_reg;
            logic [BUS_DATA_WIDTH-1:0] dc_beat_reg;

            // Capture response beat gi into the line of whichever fill is granted
            always_ff @(posedge clk) begin
                if (reset) begin
                    ic_beat_reg <= '0;
                    dc_beat_reg <= '0;
                end else if (beat_fire && cnt_reg == 3'(gi)) begin
                    if (grant_reg == G_IC) ic_beat_reg <= bus_resp;
                    else                   dc_beat_reg <= bus_resp;
                end
            end

            assign ic_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = ic_beat_reg;
            assign dc_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = dc_beat_reg;
        end
    endgenerate

endmodule
